// File: rtl/phase_timer.sv
// Per-phase cycle timer for a sequenced controller: times each phase state
// against a programmable duration and reports sticky completion flags.
// Ports: clock/reset (sync, active-high); state = controller state code;
//   pause freezes counting; cfg_we/cfg_phase/cfg_time program durations;
//   phase_done = sticky flags; done_pulse = 1-cycle completion strobe;
//   active = phase currently counting; remaining = cycles left in phase.
module phase_timer #(
  parameter int NUM_PHASES   = 5,
  parameter int CNT_W        = 8,
  parameter int STATE_W      = 3,
  parameter int FIRST_PHASE  = 2,
  parameter int DEFAULT_TIME = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [STATE_W-1:0]    state,
  input  logic                  pause,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_phase,
  input  logic [CNT_W-1:0]      cfg_time,
  output logic [NUM_PHASES-1:0] phase_done,
  output logic                  done_pulse,
  output logic                  active,
  output logic [CNT_W-1:0]      remaining
);

  logic [CNT_W-1:0]      dur [NUM_PHASES];
  logic [CNT_W-1:0]      cnt;
  logic [STATE_W-1:0]    prev_state;

  logic                  is_idle;
  logic                  in_phase;
  logic [2:0]            pidx;
  logic [NUM_PHASES-1:0] sel_mask;
  logic [CNT_W-1:0]      dur_sel;
  logic [CNT_W-1:0]      dur_eff;
  logic                  flag_sel;
  logic [CNT_W:0]        cnt_inc;
  logic                  reach;

  always_comb begin
    is_idle  = (state == '0) || (state == STATE_W'(1));
    in_phase = (int'(state) >= FIRST_PHASE) &&
               (int'(state) < FIRST_PHASE + NUM_PHASES);
    pidx     = 3'(int'(state) - FIRST_PHASE);
    sel_mask = '0;
    dur_sel  = '0;
    flag_sel = 1'b0;
    // Mux by loop so an index past NUM_PHASES never selects anything.
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (in_phase && (pidx == 3'(i))) begin
        sel_mask[i] = 1'b1;
        dur_sel     = dur[i];
        flag_sel    = phase_done[i];
      end
    end
    // A programmed duration of zero behaves as one cycle.
    dur_eff = (dur_sel == '0) ? CNT_W'(1) : dur_sel;
    // One extra bit so cnt+1 cannot wrap when the duration is all-ones.
    cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    // Also true when a shortened duration is already below the count.
    reach   = (cnt_inc >= {1'b0, dur_eff});
    // Clamp covers the window after a duration is rewritten below the count.
    remaining = (in_phase && (cnt < dur_eff)) ? (dur_eff - cnt) : '0;
    active    = in_phase && !flag_sel && !pause;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      prev_state <= '0;
      phase_done <= '0;
      done_pulse <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        dur[i] <= CNT_W'(DEFAULT_TIME);
      end
    end else begin
      prev_state <= state;
      done_pulse <= 1'b0;
      // Out-of-range phase indices match no entry and are dropped.
      for (int i = 0; i < NUM_PHASES; i++) begin
        if (cfg_we && (cfg_phase == 3'(i))) begin
          dur[i] <= cfg_time;
        end
      end
      if (is_idle) begin
        cnt        <= '0;
        phase_done <= '0;
      end else if (in_phase) begin
        if (state != prev_state) begin
          // Entering (or re-entering) a phase restarts its timing only.
          cnt <= '0;
        end else if (!pause && !flag_sel) begin
          if (reach) begin
            cnt        <= dur_eff;
            phase_done <= phase_done | sel_mask;
            done_pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
          end
        end
      end
      // Other non-phase codes hold counter and flags.
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
module tb_phase_timer;

  typedef struct packed {
    logic [7:0] row;
    logic [4:0] done;
    logic       pulse;
    logic       act;
    logic [7:0] rem;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic       pause;
  logic       cfg_we;
  logic [2:0] cfg_phase;
  logic [7:0] cfg_time;
  logic [4:0] phase_done;
  logic       done_pulse;
  logic       active;
  logic [7:0] remaining;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   row_no = 0;

  always #5 clock = ~clock;

  phase_timer dut (
    .clock      (clock),
    .reset      (reset),
    .state      (state),
    .pause      (pause),
    .cfg_we     (cfg_we),
    .cfg_phase  (cfg_phase),
    .cfg_time   (cfg_time),
    .phase_done (phase_done),
    .done_pulse (done_pulse),
    .active     (active),
    .remaining  (remaining)
  );

  // One clock cycle of stimulus; the expected outputs for this cycle are
  // queued for the monitor when chk is set.
  task automatic cyc(input logic rst, input logic [2:0] st, input logic ps,
                     input logic we, input logic [2:0] ph, input logic [7:0] tm,
                     input logic chk, input logic [4:0] e_done,
                     input logic e_pulse, input logic e_act,
                     input logic [7:0] e_rem);
    exp_t e;
    row_no++;
    reset     = rst;
    state     = st;
    pause     = ps;
    cfg_we    = we;
    cfg_phase = ph;
    cfg_time  = tm;
    if (chk) begin
      e.row   = 8'(row_no);
      e.done  = e_done;
      e.pulse = e_pulse;
      e.act   = e_act;
      e.rem   = e_rem;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: outputs are sampled on the falling edge, away from updates.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if ({phase_done, done_pulse, active, remaining} !==
            {e.done, e.pulse, e.act, e.rem}) begin
          mismatched++;
          $display("FAIL row%0d: got done=%b pulse=%b act=%b rem=%0d, want done=%b pulse=%b act=%b rem=%0d",
                   e.row, phase_done, done_pulse, active, remaining,
                   e.done, e.pulse, e.act, e.rem);
        end
      end
    end
  end

  initial begin
    //   rst st ps we ph tm chk  done    pu ac rem
    cyc(1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0); // 1 reset
    cyc(0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0); // 2 READY
    // phase 0, default duration 3
    cyc(0, 2, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 3); // 3 entry
    cyc(0, 2, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 3); // 4
    cyc(0, 2, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 2); // 5
    cyc(0, 2, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 1); // 6
    cyc(0, 2, 0, 0, 0, 0, 1, 5'b00001, 1, 0, 0); // 7 done + pulse
    cyc(0, 2, 0, 1, 1, 0, 1, 5'b00001, 0, 0, 0); // 8 dur[1]=0
    // phase 1 with zero duration -> one cycle
    cyc(0, 3, 0, 0, 0, 0, 1, 5'b00001, 0, 1, 0); // 9 entry, cnt 1 >= D
    cyc(0, 3, 0, 0, 0, 0, 1, 5'b00001, 0, 1, 1); // 10
    cyc(0, 3, 0, 1, 2, 5, 1, 5'b00011, 1, 0, 0); // 11 done, dur[2]=5
    // phase 2, duration 5, paused two cycles
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00011, 0, 1, 4); // 12 entry (cnt 1)
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00011, 0, 1, 5); // 13 cycle 1
    cyc(0, 4, 1, 0, 0, 0, 1, 5'b00011, 0, 0, 4); // 14 paused
    cyc(0, 4, 1, 0, 0, 0, 1, 5'b00011, 0, 0, 4); // 15 paused
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00011, 0, 1, 4); // 16
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00011, 0, 1, 3); // 17
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00011, 0, 1, 2); // 18
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00011, 0, 1, 1); // 19
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00111, 1, 0, 0); // 20 done
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00111, 0, 0, 0); // 21 saturated
    // clear, then leave/re-enter mid-count
    cyc(0, 0, 0, 0, 0, 0, 1, 5'b00111, 0, 0, 0); // 22 START
    cyc(0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0); // 23 flags cleared
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 5); // 24 entry
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 5); // 25
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 4); // 26
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 1); // 27 to phase 3 (cnt 2)
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 3); // 28
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 4); // 29 back (cnt 1)
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 5); // 30 restarted
    cyc(0, 4, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 4); // 31
    // phase 4, duration rewritten at counter 2
    cyc(0, 6, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 1); // 32 entry (cnt 2)
    cyc(0, 6, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 3); // 33
    cyc(0, 6, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 2); // 34
    cyc(0, 6, 0, 1, 4, 1, 1, 5'b00000, 0, 1, 1); // 35 dur[4]=1
    cyc(0, 6, 0, 0, 0, 0, 1, 5'b10000, 1, 0, 0); // 36 done
    cyc(0, 6, 0, 0, 0, 0, 1, 5'b10000, 0, 0, 0); // 37 single pulse
    cyc(0, 7, 0, 1, 5, 9, 1, 5'b10000, 0, 0, 0); // 38 non-phase hold, bad idx
    // reset mid-phase with a simultaneous write
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b10000, 0, 1, 0); // 39 entry (cnt 3)
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b10000, 0, 1, 3); // 40
    cyc(1, 5, 0, 1, 3, 7, 1, 5'b10000, 0, 1, 2); // 41 reset + write
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 3); // 42 outputs cleared, D=3
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 3); // 43
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 2); // 44
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 1); // 45
    cyc(0, 5, 0, 0, 0, 0, 1, 5'b01000, 1, 0, 0); // 46 write was discarded
    cyc(0, 0, 1, 0, 0, 0, 1, 5'b01000, 0, 0, 0); // 47 START while paused
    cyc(0, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0); // 48 cleared anyway

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
